// File: rtl/uart_receiver_parity_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// parity rule used by both the parity transmitter and the parity receiver.
package uart_receiver_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;

    // Parity bit a transmitter puts on the line; odd=1 selects odd parity
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic                 odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line (idle high) plus a
// falling-edge flag derived only from the synchronized signal.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall
);

    logic rx_meta;
    logic rx_prev;

    // Every stage resets high so that leaving reset never looks like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_receiver_parity.sv
// UART receiver for start + 8 data (LSB first) + parity + stop frames, with
// mid-bit sampling and a valid/ready holding register for the received byte.
module uart_receiver_parity
    import uart_receiver_parity_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CW    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(FRAME_BITS);

    localparam logic [CW-1:0]    HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0]    BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_BITS);

    logic                 rx_s;
    logic                 fall;
    uart_state_t          state;
    logic [CW-1:0]        cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_sample;
    logic                 sample_now;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall)
    );

    // The start bit is sampled half a bit after the edge, every later bit one full bit after that
    always_comb begin
        sample_now = 1'b0;
        if (state == START) begin
            sample_now = (cnt == HALF_END);
        end else if (state != IDLE) begin
            sample_now = (cnt == BIT_END);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_sample <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (state == IDLE || sample_now) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (fall) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                // A high start sample means the edge was a glitch
                START: begin
                    if (sample_now) begin
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= IDX_W'(1);
                        end
                    end
                end

                DATA: begin
                    if (sample_now) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (bit_idx == LAST_DATA_IDX) begin
                            state <= PARITY;
                        end
                    end
                end

                PARITY: begin
                    if (sample_now) begin
                        par_sample <= rx_s;
                        bit_idx    <= bit_idx + IDX_W'(1);
                        state      <= STOP;
                    end
                end

                // A new byte always wins over an accept in the same cycle
                STOP: begin
                    if (sample_now) begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                        parity_err <= par_sample ^ parity_bit(shreg, PARITY_ODD);
                        frame_err  <= ~rx_s;
                        overrun    <= dout_valid & ~dout_ready;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver_parity.sv
// Self-checking bench: directed and random frames on rx, compared against a
// frame-level model for an even-parity and an odd-parity receiver instance.
module tb_uart_receiver_parity;

    localparam int N   = 16;
    localparam int LAT = 2 + N / 2 + 10 * N + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       dout_ready = 1'b1;
    logic       ready2 = 1'b1;
    logic [7:0] dout, dout2;
    logic       dout_valid, dout_valid2;
    logic       parity_err, parity_err2;
    logic       frame_err, frame_err2;
    logic       overrun, overrun2;
    logic       busy, busy2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ovr1 = 0;
    logic pv1 = 1'b0;
    logic pv2 = 1'b0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        int         at;
    } cap_t;

    cap_t cap1[$];
    cap_t cap2[$];
    int   starts[$];

    uart_receiver_parity #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    uart_receiver_parity #(.CLKS_PER_BIT(N), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .rx(rx), .dout(dout2), .dout_valid(dout_valid2),
        .dout_ready(ready2), .parity_err(parity_err2), .frame_err(frame_err2),
        .overrun(overrun2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every newly written byte shows up as a valid rise or as an overrun pulse
    always @(negedge clk) begin
        pv1 <= dout_valid;
        pv2 <= dout_valid2;
        if (overrun) ovr1 <= ovr1 + 1;
        if ((dout_valid && !pv1) || overrun)
            cap1.push_back('{dout, parity_err, frame_err, cyc});
        if ((dout_valid2 && !pv2) || overrun2)
            cap2.push_back('{dout2, parity_err2, frame_err2, cyc});
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic modelPerr(input logic [7:0] d, input logic p, input logic odd);
        return ((($countones(d) + int'(p)) % 2) != int'(odd));
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s, input int nbits);
        logic [10:0] bits;
        bits = {s, p, d, 1'b0};
        @(negedge clk);
        starts.push_back(cyc);
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (N) @(negedge clk);
        end
    endtask

    task automatic idle(input int g);
        rx = 1'b1;
        repeat (g) @(negedge clk);
    endtask

    task automatic expectFrame(input string tag, input logic [7:0] d, input logic p, input logic s);
        int   w;
        int   st;
        cap_t c;
        st = (starts.size() > 0) ? starts.pop_front() : -1;
        w = 0;
        while ((cap1.size() == 0 || cap2.size() == 0) && w < 4 * N) begin
            @(negedge clk);
            w++;
        end
        checkOutput({tag, " even arrived"}, 32'(cap1.size() > 0), 1);
        if (cap1.size() > 0) begin
            c = cap1.pop_front();
            checkOutput({tag, " even dout"}, 32'(c.d), 32'(d));
            checkOutput({tag, " even parity_err"}, 32'(c.pe), 32'(modelPerr(d, p, 1'b0)));
            checkOutput({tag, " even frame_err"}, 32'(c.fe), 32'(!s));
            checkOutput({tag, " even latency"}, 32'(c.at - st), 32'(LAT));
        end
        checkOutput({tag, " odd arrived"}, 32'(cap2.size() > 0), 1);
        if (cap2.size() > 0) begin
            c = cap2.pop_front();
            checkOutput({tag, " odd dout"}, 32'(c.d), 32'(d));
            checkOutput({tag, " odd parity_err"}, 32'(c.pe), 32'(modelPerr(d, p, 1'b1)));
            checkOutput({tag, " odd frame_err"}, 32'(c.fe), 32'(!s));
        end
    endtask

    initial begin
        int g0;
        int junk;
        logic [7:0] rd;
        logic rp, rs;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset dout", 32'(dout), 0);
        checkOutput("reset dout_valid", 32'(dout_valid), 0);
        checkOutput("reset parity_err", 32'(parity_err), 0);
        checkOutput("reset frame_err", 32'(frame_err), 0);
        checkOutput("reset overrun", 32'(overrun), 0);
        checkOutput("reset busy", 32'(busy), 0);
        checkOutput("reset busy odd", 32'(busy2), 0);
        rst = 1'b0;
        idle(5);

        // Clean frame with exact latency
        applyStimulus(8'h81, 1'b0, 1'b1, 11);
        expectFrame("t1", 8'h81, 1'b0, 1'b1);
        checkOutput("t1 valid cleared", 32'(dout_valid), 0);
        idle(4);

        // Parity bit wrong for even, right for odd
        applyStimulus(8'hA5, 1'b1, 1'b1, 11);
        expectFrame("t2", 8'hA5, 1'b1, 1'b1);
        idle(4);

        // Bad stop bit followed by a long low line
        applyStimulus(8'h3C, 1'b0, 1'b0, 11);
        repeat (40 * N) @(negedge clk);
        expectFrame("t3", 8'h3C, 1'b0, 1'b0);
        checkOutput("t3 no extra frame low", 32'(cap1.size()), 0);
        checkOutput("t3 idle while low", 32'(busy), 0);
        idle(2 * N);
        checkOutput("t3 no extra frame high", 32'(cap1.size()), 0);
        checkOutput("t3 idle after rise", 32'(busy), 0);

        // Three-cycle glitch while idle
        @(negedge clk);
        rx = 1'b0;
        g0 = cyc;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        checkOutput("t4 busy after edge", 32'(busy), 1);
        repeat ((g0 + 10) - cyc) @(negedge clk);
        checkOutput("t4 busy at start sample", 32'(busy), 1);
        @(negedge clk);
        checkOutput("t4 busy dropped", 32'(busy), 0);
        idle(2 * N);
        checkOutput("t4 no glitch frame", 32'(cap1.size() + cap2.size()), 0);
        applyStimulus(8'h55, 1'b0, 1'b1, 11);
        expectFrame("t4", 8'h55, 1'b0, 1'b1);
        idle(4);

        // Back-to-back frames with the consumer stalled
        dout_ready = 1'b0;
        g0 = ovr1;
        applyStimulus(8'h11, 1'b0, 1'b1, 11);
        applyStimulus(8'h22, 1'b0, 1'b1, 11);
        expectFrame("t5a", 8'h11, 1'b0, 1'b1);
        expectFrame("t5b", 8'h22, 1'b0, 1'b1);
        checkOutput("t5 overrun pulses", 32'(ovr1 - g0), 1);
        checkOutput("t5 valid held", 32'(dout_valid), 1);
        checkOutput("t5 dout held", 32'(dout), 32'h22);
        dout_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5 valid cleared", 32'(dout_valid), 0);
        idle(4);

        // Reset in the middle of a frame
        applyStimulus(8'h7E, 1'b0, 1'b1, 5);
        rx = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6 rst dout", 32'(dout), 0);
        checkOutput("t6 rst valid", 32'(dout_valid), 0);
        checkOutput("t6 rst errs", 32'({parity_err, frame_err, overrun}), 0);
        checkOutput("t6 rst busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        junk = starts.pop_front();
        idle(2 * N);
        checkOutput("t6 no partial frame", 32'(cap1.size() + cap2.size()), 0);
        applyStimulus(8'h99, 1'b0, 1'b1, 11);
        expectFrame("t6", 8'h99, 1'b0, 1'b1);

        // Random frames: random data, occasional bad parity or stop bit
        for (int i = 0; i < 12; i++) begin
            idle($urandom_range(1, 20));
            rd = 8'($urandom);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 4) != 0);
            applyStimulus(rd, rp, rs, 11);
            expectFrame("rand", rd, rp, rs);
        end
        idle(4);
        checkOutput("final no overrun", 32'(ovr1 - g0), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
